// File: rtl/mnist_pkg.sv
// mnist_pkg: shared constants, FP32 field layout, NaN test and order-key
// function for the MNIST MLP post-processing blocks.
//   NUM_CLASSES  digits per image
//   LABEL_W      width of a predicted-digit label
//   FPW          logit width (IEEE-754 single)
package mnist_pkg;

   localparam int unsigned NUM_CLASSES = 10;
   localparam int unsigned LABEL_W     = 4;
   localparam int unsigned FPW         = 32;

   localparam logic [LABEL_W-1:0] LAST_CLASS = LABEL_W'(NUM_CLASSES - 1);

   // IEEE-754 single-precision field view of a logit
   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } fp32_t;

   // Collector run state; idle-after-run is the DONE state
   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_e;

   // Exponent all ones with a nonzero mantissa
   function automatic logic fp32_is_nan(input fp32_t x);
      return (x.exp == 8'hFF) && (x.mant != 23'd0);
   endfunction

   // Monotonic unsigned key: unsigned compare of keys equals FP order,
   // -0 sorts just below +0, any NaN maps to 0 so it loses to every number
   function automatic logic [FPW-1:0] order_key(input fp32_t x);
      logic [FPW-1:0] raw;
      raw = x;
      if (fp32_is_nan(x)) begin
         return '0;
      end else if (x.sign) begin
         return ~raw;
      end else begin
         return raw ^ 32'h8000_0000;
      end
   endfunction

endpackage

// File: rtl/mlp_argmax_collector_if.sv
// mlp_argmax_collector_if: bus between the MLP core / host and the argmax collector.
//   i_START        run start pulse (clears collector state)
//   i_OUTBUF_WE    logit write strobe
//   i_OUTBUF_ADDR  logit index img*10+class
//   i_OUTBUF_DATA  FP32 logit
//   i_RD_IMG       host label readout index
//   o_LABEL_VALID  one-cycle label pulse
//   o_LABEL_IMG    image index of the label
//   o_LABEL        predicted digit
//   o_RD_LABEL     stored label for i_RD_IMG (combinational)
//   o_ALL_DONE     all labels produced
//   o_SEQ_ERR      sticky write-order error
// master: core/host side, slave: collector side.
interface mlp_argmax_collector_if
   import mnist_pkg::*;
#(
   parameter int unsigned IMGNUM = 10
);

   localparam int unsigned NUM_LOGITS = IMGNUM * NUM_CLASSES;
   localparam int unsigned RBAW = (NUM_LOGITS > 1) ? $clog2(NUM_LOGITS) : 1;
   localparam int unsigned IBW  = (IMGNUM > 1) ? $clog2(IMGNUM) : 1;

   logic               i_START;
   logic               i_OUTBUF_WE;
   logic [RBAW-1:0]    i_OUTBUF_ADDR;
   logic [FPW-1:0]     i_OUTBUF_DATA;
   logic [IBW-1:0]     i_RD_IMG;
   logic               o_LABEL_VALID;
   logic [IBW-1:0]     o_LABEL_IMG;
   logic [LABEL_W-1:0] o_LABEL;
   logic [LABEL_W-1:0] o_RD_LABEL;
   logic               o_ALL_DONE;
   logic               o_SEQ_ERR;

   modport master (
      output i_START, i_OUTBUF_WE, i_OUTBUF_ADDR, i_OUTBUF_DATA, i_RD_IMG,
      input  o_LABEL_VALID, o_LABEL_IMG, o_LABEL, o_RD_LABEL, o_ALL_DONE, o_SEQ_ERR
   );

   modport slave (
      input  i_START, i_OUTBUF_WE, i_OUTBUF_ADDR, i_OUTBUF_DATA, i_RD_IMG,
      output o_LABEL_VALID, o_LABEL_IMG, o_LABEL, o_RD_LABEL, o_ALL_DONE, o_SEQ_ERR
   );

endinterface

// File: rtl/mlp_argmax_collector_key.sv
// fp32_order_key: combinational FP32 -> unsigned order key (NaN -> 0),
// reusable by any max/compare stage.
//   x      FP32 value
//   key_c  unsigned key, compare order equals FP order
module fp32_order_key
   import mnist_pkg::*;
(
   input  fp32_t          x,
   output logic [FPW-1:0] key_c
);

   assign key_c = order_key(x);

endmodule

// File: rtl/mlp_argmax_collector.sv
// mlp_argmax_collector: snoops the MLP core's logit writes (NUM_CLASSES per
// image, ascending address), keeps a running argmax per image, emits one
// label pulse per image, stores labels for host readout and flags completion.
//   i_CLK    clock
//   i_RST_n  asynchronous active-low reset
//   bus      collector side of mlp_argmax_collector_if (see interface header)
module mlp_argmax_collector
   import mnist_pkg::*;
#(
   parameter int unsigned IMGNUM = 10
)(
   input  logic                   i_CLK,
   input  logic                   i_RST_n,
   mlp_argmax_collector_if.slave  bus
);

   localparam int unsigned NUM_LOGITS = IMGNUM * NUM_CLASSES;
   localparam int unsigned RBAW = (NUM_LOGITS > 1) ? $clog2(NUM_LOGITS) : 1;
   localparam int unsigned IBW  = (IMGNUM > 1) ? $clog2(IMGNUM) : 1;
   localparam logic [IBW-1:0] LAST_IMG = IBW'(IMGNUM - 1);

   state_e             state_q,       state_d;
   logic [IBW-1:0]     img_cnt_q,     img_cnt_d;
   logic [LABEL_W-1:0] cls_cnt_q,     cls_cnt_d;
   logic [RBAW-1:0]    addr_cnt_q,    addr_cnt_d;
   logic [FPW-1:0]     best_key_q,    best_key_d;
   logic [LABEL_W-1:0] best_idx_q,    best_idx_d;
   logic [LABEL_W-1:0] labels_q [IMGNUM];
   logic [LABEL_W-1:0] labels_d [IMGNUM];
   logic               label_valid_q, label_valid_d;
   logic [IBW-1:0]     label_img_q,   label_img_d;
   logic [LABEL_W-1:0] label_q,       label_d;
   logic               seq_err_q,     seq_err_d;

   fp32_t          logit_c;
   logic [FPW-1:0] key_c;

   assign logit_c = bus.i_OUTBUF_DATA;

   fp32_order_key u_key (
      .x     (logit_c),
      .key_c (key_c)
   );

   // Next-state: start clear, then per-write argmax update and label emission
   always_comb begin
      state_d       = state_q;
      img_cnt_d     = img_cnt_q;
      cls_cnt_d     = cls_cnt_q;
      addr_cnt_d    = addr_cnt_q;
      best_key_d    = best_key_q;
      best_idx_d    = best_idx_q;
      labels_d      = labels_q;
      label_valid_d = 1'b0;
      label_img_d   = label_img_q;
      label_d       = label_q;
      seq_err_d     = seq_err_q;

      if (bus.i_START) begin
         // A write on the same cycle as start is dropped
         state_d     = ST_ACCUM;
         img_cnt_d   = '0;
         cls_cnt_d   = '0;
         addr_cnt_d  = '0;
         best_key_d  = '0;
         best_idx_d  = '0;
         label_img_d = '0;
         label_d     = '0;
         seq_err_d   = 1'b0;
         for (int unsigned i = 0; i < IMGNUM; i++) begin
            labels_d[i] = '0;
         end
      end else if (bus.i_OUTBUF_WE) begin
         if (state_q == ST_DONE) begin
            seq_err_d = 1'b1;
         end else begin
            // Address is only checked; the write lands at the tracked position
            if (bus.i_OUTBUF_ADDR != addr_cnt_q) begin
               seq_err_d = 1'b1;
            end
            addr_cnt_d = addr_cnt_q + RBAW'(1);

            // Strict compare keeps the lowest class index on ties
            if (cls_cnt_q == '0) begin
               best_key_d = key_c;
               best_idx_d = '0;
            end else if (key_c > best_key_q) begin
               best_key_d = key_c;
               best_idx_d = cls_cnt_q;
            end

            if (cls_cnt_q == LAST_CLASS) begin
               label_valid_d       = 1'b1;
               label_img_d         = img_cnt_q;
               label_d             = best_idx_d;
               labels_d[img_cnt_q] = best_idx_d;
               cls_cnt_d           = '0;
               if (img_cnt_q == LAST_IMG) begin
                  state_d = ST_DONE;
               end else begin
                  img_cnt_d = img_cnt_q + IBW'(1);
               end
            end else begin
               cls_cnt_d = cls_cnt_q + LABEL_W'(1);
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state_q       <= ST_ACCUM;
         img_cnt_q     <= '0;
         cls_cnt_q     <= '0;
         addr_cnt_q    <= '0;
         best_key_q    <= '0;
         best_idx_q    <= '0;
         label_valid_q <= 1'b0;
         label_img_q   <= '0;
         label_q       <= '0;
         seq_err_q     <= 1'b0;
         for (int unsigned i = 0; i < IMGNUM; i++) begin
            labels_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         img_cnt_q     <= img_cnt_d;
         cls_cnt_q     <= cls_cnt_d;
         addr_cnt_q    <= addr_cnt_d;
         best_key_q    <= best_key_d;
         best_idx_q    <= best_idx_d;
         label_valid_q <= label_valid_d;
         label_img_q   <= label_img_d;
         label_q       <= label_d;
         seq_err_q     <= seq_err_d;
         labels_q      <= labels_d;
      end
   end

   assign bus.o_LABEL_VALID = label_valid_q;
   assign bus.o_LABEL_IMG   = label_img_q;
   assign bus.o_LABEL       = label_q;
   assign bus.o_ALL_DONE    = (state_q == ST_DONE);
   assign bus.o_SEQ_ERR     = seq_err_q;

   // Host readout; out-of-range indices read as all ones
   always_comb begin
      bus.o_RD_LABEL = {LABEL_W{1'b1}};
      if (32'(bus.i_RD_IMG) < IMGNUM) begin
         bus.o_RD_LABEL = labels_q[bus.i_RD_IMG];
      end
   end

endmodule

// File: tb/tb_mlp_argmax_collector.sv
// tb_mlp_argmax_collector: directed scoreboard bench for mlp_argmax_collector.
// Stimulus pushes expected labels into a queue; a monitor pops on each label pulse.
module tb_mlp_argmax_collector;

   localparam int unsigned IMGNUM = 10;

   typedef struct {
      int img;
      int lbl;
      bit done;
      int cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   exp_t exp_q[$];
   logic [31:0] lv [10];
   int   exp_lbl [IMGNUM];

   mlp_argmax_collector_if #(.IMGNUM(IMGNUM)) bus ();

   mlp_argmax_collector #(.IMGNUM(IMGNUM)) dut (
      .i_CLK   (clk),
      .i_RST_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every label pulse must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && bus.o_LABEL_VALID) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_label: got img %0d label %0d, expected no pulse",
                     bus.o_LABEL_IMG, bus.o_LABEL);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("label_img", longint'(bus.o_LABEL_IMG), longint'(e.img));
            chk("label", longint'(bus.o_LABEL), longint'(e.lbl));
            chk("all_done_at_pulse", longint'(bus.o_ALL_DONE), longint'(e.done));
            chk("label_latency", longint'(cyc), longint'(e.cyc));
         end
      end
   end

   function automatic bit is_nan(input logic [31:0] a);
      return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
   endfunction

   // a strictly above b in FP order, NaN below everything
   function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
      if (is_nan(a)) return 1'b0;
      if (is_nan(b)) return 1'b1;
      if (a[31] != b[31]) return b[31];
      if (!a[31]) return a[30:0] > b[30:0];
      return a[30:0] < b[30:0];
   endfunction

   function automatic int model_argmax();
      int best;
      best = 0;
      for (int c = 1; c < 10; c++) begin
         if (fp_gt(lv[c], lv[best])) best = c;
      end
      return best;
   endfunction

   // Ten back-to-back writes of lv[]; bad_cls gets bad_addr instead of its own address
   task automatic send_img(input int img, input int lbl, input int bad_cls,
                           input int bad_addr, input bit done);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.i_OUTBUF_WE   = 1'b1;
         bus.i_OUTBUF_ADDR = 7'((c == bad_cls) ? bad_addr : img * 10 + c);
         bus.i_OUTBUF_DATA = lv[c];
         if (c == 9) begin
            exp_t e;
            e.img = img;
            e.lbl = (lbl < 0) ? model_argmax() : lbl;
            e.done = done;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
            exp_lbl[img] = e.lbl;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.i_OUTBUF_WE = 1'b0;
         bus.i_START     = 1'b0;
      end
   endtask

   task automatic rd_chk(input int img, input int exp);
      bus.i_RD_IMG = 4'(img);
      #1;
      chk($sformatf("rd_label[%0d]", img), longint'(bus.o_RD_LABEL), longint'(exp));
   endtask

   task automatic fill(input logic [31:0] dflt);
      for (int c = 0; c < 10; c++) lv[c] = dflt;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      bus.i_START = 1'b0;
      bus.i_OUTBUF_WE = 1'b0;
      bus.i_OUTBUF_ADDR = '0;
      bus.i_OUTBUF_DATA = '0;
      bus.i_RD_IMG = '0;
      repeat (3) @(negedge clk);
      chk("reset_label_valid", longint'(bus.o_LABEL_VALID), 0);
      chk("reset_all_done", longint'(bus.o_ALL_DONE), 0);
      chk("reset_seq_err", longint'(bus.o_SEQ_ERR), 0);
      rd_chk(0, 0);
      rst_n = 1'b1;

      // Run 1: five directed images, five random ones, back-to-back
      lv[0] = 32'h0000_0000; lv[1] = 32'h3F80_0000; lv[2] = 32'h4000_0000;
      lv[3] = 32'h4040_0000; lv[4] = 32'h4080_0000; lv[5] = 32'h40A0_0000;
      lv[6] = 32'h40C0_0000; lv[7] = 32'h40E0_0000; lv[8] = 32'h4100_0000;
      lv[9] = 32'h4110_0000;
      send_img(0, 9, -1, 0, 1'b0);
      fill(32'hC000_0000); lv[3] = 32'hBF00_0000;
      send_img(1, 3, -1, 0, 1'b0);
      fill(32'hBF80_0000); lv[1] = 32'h8000_0000; lv[2] = 32'h0000_0000;
      send_img(2, 2, -1, 0, 1'b0);
      fill(32'h3F80_0000); lv[4] = 32'h40A0_0000; lv[7] = 32'h40A0_0000;
      send_img(3, 4, -1, 0, 1'b0);
      fill(32'hBF80_0000); lv[0] = 32'h7FC0_0000;
      send_img(4, 1, -1, 0, 1'b0);
      for (int i = 5; i < 10; i++) begin
         for (int c = 0; c < 10; c++) lv[c] = $urandom();
         send_img(i, -1, -1, 0, (i == 9));
      end
      idle(3);
      chk("run1_all_done", longint'(bus.o_ALL_DONE), 1);
      chk("run1_seq_err", longint'(bus.o_SEQ_ERR), 0);
      for (int i = 0; i < 10; i++) rd_chk(i, exp_lbl[i]);
      rd_chk(12, 15);

      // Write after done: ignored, sets the sticky error
      @(negedge clk);
      bus.i_OUTBUF_WE = 1'b1;
      bus.i_OUTBUF_ADDR = '0;
      bus.i_OUTBUF_DATA = 32'h4000_0000;
      idle(2);
      chk("extra_write_seq_err", longint'(bus.o_SEQ_ERR), 1);
      chk("extra_write_all_done", longint'(bus.o_ALL_DONE), 1);

      // Run 2: start clears, then an out-of-order address
      @(negedge clk);
      bus.i_START = 1'b1;
      idle(1);
      chk("start_all_done", longint'(bus.o_ALL_DONE), 0);
      chk("start_seq_err", longint'(bus.o_SEQ_ERR), 0);
      rd_chk(3, 0);
      for (int c = 0; c < 10; c++) lv[c] = $urandom();
      send_img(0, -1, -1, 0, 1'b0);
      for (int c = 0; c < 10; c++) lv[c] = $urandom();
      send_img(1, -1, 5, 16, 1'b0);
      idle(2);
      chk("skip_seq_err", longint'(bus.o_SEQ_ERR), 1);
      for (int c = 0; c < 10; c++) lv[c] = $urandom();
      send_img(2, -1, -1, 0, 1'b0);
      idle(2);
      chk("seq_err_sticky", longint'(bus.o_SEQ_ERR), 1);
      rd_chk(1, exp_lbl[1]);

      // Five logits of image 3, then start coincident with a write, then fresh image 0
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.i_OUTBUF_WE = 1'b1;
         bus.i_OUTBUF_ADDR = 7'(30 + c);
         bus.i_OUTBUF_DATA = 32'h3F80_0000;
      end
      @(negedge clk);
      bus.i_START = 1'b1;
      bus.i_OUTBUF_ADDR = 7'd35;
      bus.i_OUTBUF_DATA = 32'h4700_0000;
      @(negedge clk);
      bus.i_START = 1'b0;
      bus.i_OUTBUF_WE = 1'b0;
      lv[0] = 32'h0000_0000; lv[1] = 32'h3F80_0000; lv[2] = 32'h4000_0000;
      lv[3] = 32'h4040_0000; lv[4] = 32'h4080_0000; lv[5] = 32'h40A0_0000;
      lv[6] = 32'h40C0_0000; lv[7] = 32'h40E0_0000; lv[8] = 32'h4100_0000;
      lv[9] = 32'h4110_0000;
      send_img(0, 9, -1, 0, 1'b0);
      idle(2);
      chk("restart_seq_err", longint'(bus.o_SEQ_ERR), 0);
      rd_chk(0, 9);
      rd_chk(1, 0);

      // Async reset in the middle of image 1
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         bus.i_OUTBUF_WE = 1'b1;
         bus.i_OUTBUF_ADDR = 7'(10 + c);
         bus.i_OUTBUF_DATA = 32'h3F80_0000;
      end
      @(negedge clk);
      bus.i_OUTBUF_WE = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("areset_label_valid", longint'(bus.o_LABEL_VALID), 0);
      chk("areset_label", longint'(bus.o_LABEL), 0);
      chk("areset_all_done", longint'(bus.o_ALL_DONE), 0);
      chk("areset_seq_err", longint'(bus.o_SEQ_ERR), 0);
      rd_chk(0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      fill(32'h3F80_0000); lv[4] = 32'h40A0_0000; lv[7] = 32'h40A0_0000;
      send_img(0, 4, -1, 0, 1'b0);
      idle(3);
      chk("post_reset_seq_err", longint'(bus.o_SEQ_ERR), 0);
      chk("scoreboard_drained", longint'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
